// File: rtl/mult_result_accumulator.sv
// Sums a programmable-length block of signed multiplier products into a saturating
// accumulator and presents each block result through a valid/ready handshake.
module mult_result_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     rst_n,
  input  logic signed [PROD_W-1:0] prod_in,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic        [CNT_W-1:0]  block_len,
  input  logic                     clear,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     acc_valid,
  input  logic                     acc_ready,
  output logic                     sat_flag,
  output logic                     busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [CNT_W:0]          cnt;
  logic [CNT_W:0]          cnt_inc;
  logic [CNT_W:0]          len;
  logic [CNT_W:0]          len_sel;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W:0]   sum_p0;
  logic signed [ACC_W-1:0] sum_sat_p0;
  logic                    ovf_p0;
  logic                    accept;

  // Clamp an ACC_W+1 bit sum back into ACC_W bits.
  function automatic logic signed [ACC_W-1:0] sat_clip(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  function automatic logic sat_ovf(input logic signed [ACC_W:0] s);
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction

  assign accept    = prod_valid & prod_ready;
  assign acc_valid = (state == HOLD);
  assign busy      = (state == ACCUM);
  assign cnt_inc   = cnt + 1'b1;
  // A block length of zero encodes the full 2^CNT_W products.
  assign len_sel   = (block_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, block_len};
  assign prod_ext  = {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};

  // Stage p0: widened sum and saturation of the running total.
  always_comb begin
    sum_p0     = {acc_out[ACC_W-1], acc_out} + {prod_ext[ACC_W-1], prod_ext};
    sum_sat_p0 = sat_clip(sum_p0);
    ovf_p0     = sat_ovf(sum_p0);
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = (len_sel == 1) ? HOLD : ACCUM;
        ACCUM:   if (accept && (cnt_inc == len)) state_nxt = HOLD;
        HOLD:    if (acc_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p1: registered state, count and accumulator.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prod_ready <= 1'b0;
      cnt        <= '0;
      len        <= '0;
      acc_out    <= '0;
      sat_flag   <= 1'b0;
    end else begin
      state      <= state_nxt;
      prod_ready <= (state_nxt != HOLD);
      if (clear) begin
        cnt <= '0;
      end else if (accept) begin
        if (state == IDLE) begin
          acc_out  <= prod_ext;
          cnt      <= {{CNT_W{1'b0}}, 1'b1};
          len      <= len_sel;
          sat_flag <= 1'b0;
        end else begin
          acc_out <= sum_sat_p0;
          cnt     <= cnt_inc;
          if (ovf_p0) sat_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_result_accumulator.sv
// Directed bench: default-width accumulator plus an 18-bit instance that shares the
// same input stream so saturation can be reached in a short block.
module tb_mult_result_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] prod_in;
  logic               prod_valid;
  logic        [7:0]  block_len;
  logic               clear;
  logic               acc_ready;

  logic               prod_ready_a, acc_valid_a, sat_a, busy_a;
  logic signed [23:0] acc_out_a;
  logic               prod_ready_b, acc_valid_b, sat_b, busy_b;
  logic signed [17:0] acc_out_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic busy_bad;

  always #5 clk = ~clk;

  mult_result_accumulator dut_a (
    .wb_clk_i(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready_a), .block_len(block_len), .clear(clear),
    .acc_out(acc_out_a), .acc_valid(acc_valid_a), .acc_ready(acc_ready),
    .sat_flag(sat_a), .busy(busy_a)
  );

  mult_result_accumulator #(.ACC_W(18)) dut_b (
    .wb_clk_i(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready_b), .block_len(block_len), .clear(clear),
    .acc_out(acc_out_b), .acc_valid(acc_valid_b), .acc_ready(acc_ready),
    .sat_flag(sat_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [15:0] v);
    prod_in    = v;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; prod_in = '0; prod_valid = 1'b0; block_len = '0;
    clear = 1'b0; acc_ready = 1'b0;
    #12;
    chk("rst_acc_valid", acc_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_acc_out", acc_out_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_prod_ready", prod_ready_a, 0);
    #4 rst_n = 1'b1;
    tick();
    chk("post_rst_prod_ready", prod_ready_a, 1);

    // Basic block of four
    block_len = 8'd4; acc_ready = 1'b1;
    push(16'sd100);
    chk("t1_busy_first", busy_a, 1);
    chk("t1_acc_first", acc_out_a, 100);
    push(-16'sd50);
    push(16'sd300);
    chk("t1_no_valid_early", acc_valid_a, 0);
    push(16'sd7);
    chk("t1_acc_valid", acc_valid_a, 1);
    chk("t1_acc_out", acc_out_a, 357);
    chk("t1_sat", sat_a, 0);
    chk("t1_hold_ready", prod_ready_a, 0);
    chk("t1_hold_busy", busy_a, 0);
    tick();
    chk("t1_idle_valid", acc_valid_a, 0);
    chk("t1_idle_ready", prod_ready_a, 1);

    // Saturation on the 18-bit instance
    block_len = 8'd5;
    for (int i = 0; i < 5; i++) push(16'sd32767);
    chk("t2_b_valid", acc_valid_b, 1);
    chk("t2_b_clamp", acc_out_b, 131071);
    chk("t2_b_sat", sat_b, 1);
    chk("t2_a_nosat_sum", acc_out_a, 163835);
    chk("t2_a_sat", sat_a, 0);
    tick();
    chk("t2_b_sat_held_idle", sat_b, 1);
    block_len = 8'd2;
    push(-16'sd32768);
    chk("t2_b_sat_cleared", sat_b, 0);
    push(-16'sd32768);
    chk("t2_b_neg_sum", acc_out_b, -65536);
    chk("t2_b_neg_sat", sat_b, 0);
    chk("t2_b_valid2", acc_valid_b, 1);
    tick();

    // Backpressure with product held valid
    acc_ready = 1'b0; block_len = 8'd2;
    prod_in = 16'sd16384; prod_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", acc_valid_a, 1);
      chk("t3_hold_acc", acc_out_a, 32768);
      chk("t3_hold_ready", prod_ready_a, 0);
      tick();
    end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk("t3_idle_valid", acc_valid_a, 0);
    chk("t3_idle_ready", prod_ready_a, 1);
    chk("t3_idle_acc_kept", acc_out_a, 32768);
    tick();
    chk("t3_new_first_busy", busy_a, 1);
    chk("t3_new_first_acc", acc_out_a, 16384);
    tick();
    prod_valid = 1'b0;
    chk("t3_new_block_valid", acc_valid_a, 1);
    chk("t3_new_block_acc", acc_out_a, 32768);
    acc_ready = 1'b1;
    tick();

    // Full-length block with gaps
    block_len = 8'd0; busy_bad = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(1, 3)) begin
          tick();
          if (busy_a !== 1'b1 || acc_valid_a !== 1'b0) busy_bad = 1'b1;
        end
      end
      push(16'sd1);
      if (i < 255 && (busy_a !== 1'b1 || acc_valid_a !== 1'b0)) busy_bad = 1'b1;
    end
    chk("t4_busy_throughout", busy_bad, 0);
    chk("t4_valid", acc_valid_a, 1);
    chk("t4_acc", acc_out_a, 256);
    chk("t4_busy_end", busy_a, 0);
    tick();

    // Clear mid-block with a product in the same cycle
    block_len = 8'd4;
    push(16'sd1);
    push(16'sd2);
    prod_in = 16'sd99; prod_valid = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; prod_valid = 1'b0;
    chk("t5_clear_busy", busy_a, 0);
    chk("t5_clear_valid", acc_valid_a, 0);
    chk("t5_clear_acc_kept", acc_out_a, 3);
    chk("t5_clear_ready", prod_ready_a, 1);
    tick();
    chk("t5_still_no_valid", acc_valid_a, 0);
    push(16'sd1); push(16'sd2); push(16'sd3); push(16'sd4);
    chk("t5_fresh_valid", acc_valid_a, 1);
    chk("t5_fresh_acc", acc_out_a, 10);
    tick();

    // Asynchronous reset mid-ACCUM
    block_len = 8'd4;
    push(16'sd5);
    push(16'sd6);
    #2 rst_n = 1'b0;
    #1;
    chk("t6a_valid", acc_valid_a, 0);
    chk("t6a_busy", busy_a, 0);
    chk("t6a_acc", acc_out_a, 0);
    chk("t6a_sat", sat_a, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("t6a_ready", prod_ready_a, 1);

    // Asynchronous reset during HOLD
    block_len = 8'd1; acc_ready = 1'b0;
    push(-16'sd7);
    chk("t6b_hold_valid", acc_valid_a, 1);
    chk("t6b_hold_acc", acc_out_a, -7);
    #3 rst_n = 1'b0;
    #1;
    chk("t6b_valid", acc_valid_a, 0);
    chk("t6b_acc", acc_out_a, 0);
    chk("t6b_busy", busy_a, 0);
    chk("t6b_ready_in_rst", prod_ready_a, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("t6b_ready", prod_ready_a, 1);
    push(-16'sd7);
    chk("t6b_after_valid", acc_valid_a, 1);
    chk("t6b_after_acc", acc_out_a, -7);
    acc_ready = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
